// File: rtl/rom_dump_hex_tx.sv
`default_nettype none
// ============================================================================
// Module      : rom_dump_hex_tx
// Description : Reads a run of 16-bit words from memory and streams them out
//               as ASCII hex text: "@AAAA\n" followed by lines of "DDDD"
//               words separated by spaces, WPL words per line.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_dump_hex_tx #(
    parameter int WPL    = 8,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] beg_adr,
    input  logic [15:0] cnt,
    output logic        busy,
    output logic        done,
    output logic [15:0] mem_adr,
    output logic        mem_rd,
    input  logic [15:0] mem_dat,
    output logic [7:0]  tx_dat,
    output logic        tx_vld,
    input  logic        tx_rdy
);

    localparam logic [3:0] c_st_idle = 4'd0;
    localparam logic [3:0] c_st_at   = 4'd1;
    localparam logic [3:0] c_st_ahex = 4'd2;
    localparam logic [3:0] c_st_alf  = 4'd3;
    localparam logic [3:0] c_st_rd   = 4'd4;
    localparam logic [3:0] c_st_wt   = 4'd5;
    localparam logic [3:0] c_st_dhex = 4'd6;
    localparam logic [3:0] c_st_sep  = 4'd7;
    localparam logic [3:0] c_st_fin  = 4'd8;

    localparam logic [7:0] c_ch_at = 8'h40;
    localparam logic [7:0] c_ch_lf = 8'h0A;
    localparam logic [7:0] c_ch_sp = 8'h20;

    logic [3:0]  r_state_q,   w_state_d;
    logic [15:0] r_adr_q,     w_adr_d;
    logic [15:0] r_rem_q,     w_rem_d;
    logic [4:0]  r_line_q,    w_line_d;
    logic [15:0] r_shift_q,   w_shift_d;
    logic [1:0]  r_nib_q,     w_nib_d;
    logic [1:0]  r_wait_q,    w_wait_d;
    logic        r_busy_q,    w_busy_d;
    logic        r_done_q,    w_done_d;
    logic        r_mem_rd_q,  w_mem_rd_d;
    logic [15:0] r_mem_adr_q, w_mem_adr_d;
    logic        r_tx_vld_q,  w_tx_vld_d;
    logic [7:0]  r_tx_dat_q,  w_tx_dat_d;
    logic        w_free;

    // Uppercase ASCII for one nibble
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

    // The output byte slot is free when empty or being accepted this edge
    assign w_free = !r_tx_vld_q || tx_rdy;

    // Next-state logic: sequencing, byte generation and memory reads
    always_comb begin
        w_state_d   = r_state_q;
        w_adr_d     = r_adr_q;
        w_rem_d     = r_rem_q;
        w_line_d    = r_line_q;
        w_shift_d   = r_shift_q;
        w_nib_d     = r_nib_q;
        w_wait_d    = r_wait_q;
        w_busy_d    = r_busy_q;
        w_done_d    = 1'b0;
        w_mem_rd_d  = 1'b0;
        w_mem_adr_d = r_mem_adr_q;
        w_tx_vld_d  = r_tx_vld_q && !tx_rdy;
        w_tx_dat_d  = r_tx_dat_q;

        case (r_state_q)
            c_st_idle: begin
                if (start) begin
                    if (cnt != 16'd0) begin
                        w_adr_d   = beg_adr;
                        w_rem_d   = cnt;
                        w_shift_d = beg_adr;
                        w_nib_d   = 2'd0;
                        w_line_d  = 5'd0;
                        w_busy_d  = 1'b1;
                        w_state_d = c_st_at;
                    end else begin
                        w_done_d  = 1'b1;
                    end
                end
            end
            c_st_at: begin
                if (w_free) begin
                    w_tx_vld_d = 1'b1;
                    w_tx_dat_d = c_ch_at;
                    w_state_d  = c_st_ahex;
                end
            end
            c_st_ahex, c_st_dhex: begin
                if (w_free) begin
                    w_tx_vld_d = 1'b1;
                    w_tx_dat_d = hex_ascii(r_shift_q[15:12]);
                    w_shift_d  = {r_shift_q[11:0], 4'h0};
                    w_nib_d    = r_nib_q + 2'd1;
                    if (r_nib_q == 2'd3) begin
                        w_state_d = (r_state_q == c_st_ahex) ? c_st_alf : c_st_sep;
                    end
                end
            end
            c_st_alf: begin
                if (w_free) begin
                    w_tx_vld_d = 1'b1;
                    w_tx_dat_d = c_ch_lf;
                    w_state_d  = c_st_rd;
                end
            end
            // Read only once the preceding separator has left the slot
            c_st_rd: begin
                if (w_free) begin
                    w_mem_rd_d  = 1'b1;
                    w_mem_adr_d = r_adr_q;
                    w_adr_d     = r_adr_q + 16'd1;
                    w_rem_d     = r_rem_q - 16'd1;
                    w_line_d    = r_line_q + 5'd1;
                    w_wait_d    = 2'd0;
                    w_state_d   = c_st_wt;
                end
            end
            c_st_wt: begin
                if (r_wait_q == 2'(RD_LAT)) begin
                    w_shift_d = mem_dat;
                    w_nib_d   = 2'd0;
                    w_state_d = c_st_dhex;
                end else begin
                    w_wait_d  = r_wait_q + 2'd1;
                end
            end
            c_st_sep: begin
                if (w_free) begin
                    w_tx_vld_d = 1'b1;
                    if (r_rem_q == 16'd0) begin
                        w_tx_dat_d = c_ch_lf;
                        w_state_d  = c_st_fin;
                    end else if (r_line_q == 5'(WPL)) begin
                        w_tx_dat_d = c_ch_lf;
                        w_line_d   = 5'd0;
                        w_state_d  = c_st_rd;
                    end else begin
                        w_tx_dat_d = c_ch_sp;
                        w_state_d  = c_st_rd;
                    end
                end
            end
            // Completion is reported only after the final LF is accepted
            c_st_fin: begin
                if (w_free) begin
                    w_done_d  = 1'b1;
                    w_busy_d  = 1'b0;
                    w_state_d = c_st_idle;
                end
            end
            default: begin
                w_state_d = c_st_idle;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= c_st_idle;
            r_adr_q     <= 16'd0;
            r_rem_q     <= 16'd0;
            r_line_q    <= 5'd0;
            r_shift_q   <= 16'd0;
            r_nib_q     <= 2'd0;
            r_wait_q    <= 2'd0;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
            r_mem_rd_q  <= 1'b0;
            r_mem_adr_q <= 16'd0;
            r_tx_vld_q  <= 1'b0;
            r_tx_dat_q  <= 8'd0;
        end else begin
            r_state_q   <= w_state_d;
            r_adr_q     <= w_adr_d;
            r_rem_q     <= w_rem_d;
            r_line_q    <= w_line_d;
            r_shift_q   <= w_shift_d;
            r_nib_q     <= w_nib_d;
            r_wait_q    <= w_wait_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
            r_mem_rd_q  <= w_mem_rd_d;
            r_mem_adr_q <= w_mem_adr_d;
            r_tx_vld_q  <= w_tx_vld_d;
            r_tx_dat_q  <= w_tx_dat_d;
        end
    end

    assign busy    = r_busy_q;
    assign done    = r_done_q;
    assign mem_rd  = r_mem_rd_q;
    assign mem_adr = r_mem_adr_q;
    assign tx_vld  = r_tx_vld_q;
    assign tx_dat  = r_tx_dat_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_dump_hex_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_dump_hex_tx
// Description : Self-checking bench for rom_dump_hex_tx. Instance A uses
//               WPL=8/RD_LAT=1, instance B uses WPL=2/RD_LAT=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_dump_hex_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [15:0] beg_adr, cnt;
    logic        tx_rdy;

    logic        busy_a, done_a, mem_rd_a, tx_vld_a;
    logic [15:0] mem_adr_a, mem_dat_a;
    logic [7:0]  tx_dat_a;
    logic        busy_b, done_b, mem_rd_b, tx_vld_b;
    logic [15:0] mem_adr_b, mem_dat_b;
    logic [7:0]  tx_dat_b;

    logic [15:0] mem [0:65535];
    logic [15:0] a_s1, b_s1, b_s2;

    logic [7:0]  exp_q[$];
    logic [15:0] rd_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          act = 0;
    bit          stall = 0;
    bit          prev_stall = 0;
    bit          prev_rst = 0;
    logic [7:0]  prev_dat = 8'd0;

    rom_dump_hex_tx u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .beg_adr(beg_adr), .cnt(cnt),
        .busy(busy_a), .done(done_a), .mem_adr(mem_adr_a), .mem_rd(mem_rd_a),
        .mem_dat(mem_dat_a), .tx_dat(tx_dat_a), .tx_vld(tx_vld_a), .tx_rdy(tx_rdy)
    );

    rom_dump_hex_tx #(.WPL(2), .RD_LAT(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .beg_adr(beg_adr), .cnt(cnt),
        .busy(busy_b), .done(done_b), .mem_adr(mem_adr_b), .mem_rd(mem_rd_b),
        .mem_dat(mem_dat_b), .tx_dat(tx_dat_b), .tx_vld(tx_vld_b), .tx_rdy(tx_rdy)
    );

    initial forever #5 clk = ~clk;

    // Memory model: data is valid only in the exact cycle RD_LAT after the strobe
    always @(posedge clk) begin
        a_s1 <= mem_rd_a ? mem[mem_adr_a] : 16'hDEAD;
        b_s1 <= mem_rd_b ? mem[mem_adr_b] : 16'hDEAD;
        b_s2 <= b_s1;
    end
    assign mem_dat_a = a_s1;
    assign mem_dat_b = b_s2;

    task automatic chk(input bit ok, input string name, input logic [31:0] act_v,
                       input logic [31:0] exp_v);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act_v, exp_v);
        end
    endtask

    function automatic string hex4(input logic [15:0] v);
        string digits;
        string s;
        digits = "0123456789ABCDEF";
        s = "";
        for (int i = 3; i >= 0; i--) begin
            s = {s, string'(digits[(v >> (4 * i)) & 16'hF])};
        end
        return s;
    endfunction

    // Expected text of one dump built directly from the format rules
    function automatic string model_text(input logic [15:0] beg, input int n, input int wpl);
        string s;
        logic [15:0] a;
        s = {"@", hex4(beg), "\n"};
        for (int k = 0; k < n; k++) begin
            a = beg + 16'(k);
            s = {s, hex4(mem[a])};
            if (k == n - 1)             s = {s, "\n"};
            else if ((k + 1) % wpl == 0) s = {s, "\n"};
            else                         s = {s, " "};
        end
        return s;
    endfunction

    task automatic load_exp(input string s, input logic [15:0] beg, input int n);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        for (int k = 0; k < n; k++) rd_q.push_back(beg + 16'(k));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (stall) tx_rdy = ($urandom_range(0, 99) >= 30);
        else       tx_rdy = 1'b1;
    endtask

    // Per-cycle checker of the active instance against the model queues
    task automatic compare_loop();
        logic        vld, rd, bsy, dn;
        logic [7:0]  dat;
        logic [15:0] adr;
        logic [7:0]  eb;
        logic [15:0] ea;
        forever begin
            @(negedge clk);
            vld = act ? tx_vld_b  : tx_vld_a;
            dat = act ? tx_dat_b  : tx_dat_a;
            rd  = act ? mem_rd_b  : mem_rd_a;
            adr = act ? mem_adr_b : mem_adr_a;
            dn  = act ? done_b    : done_a;
            bsy = act ? busy_a    : busy_b;
            chk(!(bsy || (act ? (tx_vld_a | mem_rd_a | done_a) : (tx_vld_b | mem_rd_b | done_b))),
                "idle_inst_quiet", 32'(act), 32'(act));
            if (prev_stall && !prev_rst) begin
                chk(vld && dat == prev_dat, "tx_hold", {23'd0, vld, dat}, {24'd1, prev_dat});
            end
            if (vld && tx_rdy && !rst) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_byte", 32'(dat), 32'hFFFF_FFFF);
                end else begin
                    eb = exp_q.pop_front();
                    chk(dat == eb, "tx_byte", 32'(dat), 32'(eb));
                end
            end
            if (rd && !rst) begin
                if (rd_q.size() == 0) begin
                    chk(1'b0, "extra_read", 32'(adr), 32'hFFFF_FFFF);
                end else begin
                    ea = rd_q.pop_front();
                    chk(adr == ea, "read_addr", 32'(adr), 32'(ea));
                end
            end
            if (dn) done_cnt++;
            prev_stall = vld && !tx_rdy;
            prev_dat   = dat;
            prev_rst   = rst;
        end
    endtask

    task automatic wait_done(input string name, input int d0);
        int budget;
        budget = 3000;
        while (done_cnt == d0 && budget > 0) begin
            tick();
            budget--;
        end
        chk(done_cnt == d0 + 1, {name, "_done_seen"}, 32'(done_cnt), 32'(d0 + 1));
        repeat (5) tick();
        chk(exp_q.size() == 0, {name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
        chk(rd_q.size() == 0, {name, "_reads_left"}, 32'(rd_q.size()), 32'd0);
        chk((act ? busy_b : busy_a) == 1'b0, {name, "_busy_after"}, 32'(act ? busy_b : busy_a), 32'd0);
        chk(done_cnt == d0 + 1, {name, "_single_done"}, 32'(done_cnt), 32'(d0 + 1));
    endtask

    task automatic pulse_start();
        if (act == 0) start_a = 1'b1; else start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic dump(input string name, input logic [15:0] beg, input int n, input int wpl);
        int d0;
        d0 = done_cnt;
        load_exp(model_text(beg, n, wpl), beg, n);
        beg_adr = beg;
        cnt     = 16'(n);
        pulse_start();
        wait_done(name, d0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(busy_a == 0,        {tag, "_busy"},    32'(busy_a),    0);
        chk(done_a == 0,        {tag, "_done"},    32'(done_a),    0);
        chk(mem_rd_a == 0,      {tag, "_mem_rd"},  32'(mem_rd_a),  0);
        chk(mem_adr_a == 16'd0, {tag, "_mem_adr"}, 32'(mem_adr_a), 0);
        chk(tx_vld_a == 0,      {tag, "_tx_vld"},  32'(tx_vld_a),  0);
        chk(tx_dat_a == 8'd0,   {tag, "_tx_dat"},  32'(tx_dat_a),  0);
    endtask

    initial begin
        string s;
        int    d0;
        int    budget;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        beg_adr = 16'd0; cnt = 16'd0; tx_rdy = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 7 + 3);
        fork
            compare_loop();
        join_none
        repeat (3) tick();
        chk_reset_vals("rst_a");
        chk(busy_b == 0 && done_b == 0 && mem_rd_b == 0 && tx_vld_b == 0 &&
            mem_adr_b == 16'd0 && tx_dat_b == 8'd0, "rst_b_outputs",
            {busy_b, done_b, mem_rd_b, tx_vld_b, mem_adr_b, tx_dat_b}, 0);
        rst = 1'b0;
        tick();

        // Basic dump with latency checks
        mem[16'h0010] = 16'h1234; mem[16'h0011] = 16'hABCD; mem[16'h0012] = 16'h0000;
        s = model_text(16'h0010, 3, 8);
        chk(s == "@0010\n1234 ABCD 0000\n", "model_pin_basic", 32'(s.len()), 32'd21);
        act = 0;
        d0 = done_cnt;
        load_exp(s, 16'h0010, 3);
        beg_adr = 16'h0010; cnt = 16'd3;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk(busy_a == 1'b1, "busy_cycle1", 32'(busy_a), 1);
        chk(tx_vld_a == 1'b0, "vld_cycle1", 32'(tx_vld_a), 0);
        tick();
        chk(tx_vld_a == 1'b1 && tx_dat_a == 8'h40, "first_byte_cycle2",
            {23'd0, tx_vld_a, tx_dat_a}, 32'h140);
        wait_done("basic", d0);

        // Zero-length request
        d0 = done_cnt;
        beg_adr = 16'h0500; cnt = 16'd0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk(done_a == 1'b1, "cnt0_done", 32'(done_a), 1);
        chk(busy_a == 1'b0, "cnt0_busy", 32'(busy_a), 0);
        tick();
        chk(done_a == 1'b0, "cnt0_done_drop", 32'(done_a), 0);
        repeat (10) tick();
        chk(done_cnt == d0 + 1, "cnt0_single_done", 32'(done_cnt), 32'(d0 + 1));

        // Same dump under random back-pressure
        stall = 1;
        dump("stall", 16'h0010, 3, 8);
        stall = 0;

        // Address wrap
        mem[16'hFFFE] = 16'hBEEF; mem[16'hFFFF] = 16'h0001; mem[16'h0000] = 16'h2A5C;
        s = model_text(16'hFFFE, 3, 8);
        chk(s == "@FFFE\nBEEF 0001 2A5C\n", "model_pin_wrap", 32'(s.len()), 32'd21);
        dump("wrap", 16'hFFFE, 3, 8);

        // Short lines and two-cycle read latency
        for (int k = 0; k < 5; k++) mem[16'h0100 + k] = 16'h0100 + 16'(k);
        s = model_text(16'h0100, 5, 2);
        chk(s == "@0100\n0100 0101\n0102 0103\n0104\n", "model_pin_wpl2", 32'(s.len()), 32'd31);
        act = 1;
        dump("wpl2", 16'h0100, 5, 2);
        act = 0;
        tick();

        // Reset in the middle of a data word, with an ignored start beforehand
        d0 = done_cnt;
        load_exp(model_text(16'h0010, 3, 8), 16'h0010, 3);
        beg_adr = 16'h0010; cnt = 16'd3;
        pulse_start();
        repeat (2) tick();
        beg_adr = 16'h0200; cnt = 16'd2;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        budget = 500;
        while (exp_q.size() > 14 && budget > 0) begin
            tick();
            budget--;
        end
        chk(exp_q.size() == 14, "reach_dhex", 32'(exp_q.size()), 32'd14);
        rst = 1'b1;
        tick();
        chk_reset_vals("midrst");
        exp_q.delete();
        rd_q.delete();
        rst = 1'b0;
        repeat (30) tick();
        chk(done_cnt == d0, "no_ghost_dump", 32'(done_cnt), 32'(d0));
        dump("after_rst", 16'h0010, 3, 8);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
